// File: rtl/steer_en_pkg.sv
// rtl/steer_en_pkg.sv - state enum and default thresholds for the steer enable controller
package steer_en_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_STEER = 2'd2,
    ST_FAULT = 2'd3
  } steer_state_e;

  localparam int DEF_LD_W         = 12;
  localparam int DEF_MIN_RIDER_WT = 'h200;
  localparam int DEF_WT_HYST      = 'h40;
  localparam int DEF_ENTER_SHIFT  = 2;
  localparam int DEF_EXIT_SHIFT   = 4;
  localparam int DEF_OFF_SAMPLES  = 4;

  localparam int unsigned TMR_TICKS_FAST = 2**14;
  localparam int unsigned TMR_TICKS_SLOW = 67_000_000;

  // Short timer for simulation, ~1 s at 67 MHz for silicon.
  function automatic int unsigned tmr_ticks(input bit fast);
    return fast ? TMR_TICKS_FAST : TMR_TICKS_SLOW;
  endfunction

endpackage

// File: rtl/steer_en_ctrl_tmr.sv
// rtl/steer_en_ctrl_tmr.sv - settle timer for the WAIT state, saturating at full
module steer_tmr #(
  parameter int unsigned TMR_TICKS = 16384
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic full
);

  localparam int CW = $clog2(TMR_TICKS);
  localparam logic [CW-1:0] LAST = CW'(TMR_TICKS - 1);

  logic [CW-1:0] cnt;

  assign full = (cnt == LAST);

  // Count while running, hold at full so a late sample still sees it, clear otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n || !run || clr) begin
      cnt <= '0;
    end else if (!full) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/steer_en_ctrl.sv
// rtl/steer_en_ctrl.sv - rider presence / lean controller gating steering enable
module steer_en_ctrl
  import steer_en_pkg::*;
#(
  parameter int LD_W         = DEF_LD_W,
  parameter int MIN_RIDER_WT = DEF_MIN_RIDER_WT,
  parameter int WT_HYST      = DEF_WT_HYST,
  parameter int ENTER_SHIFT  = DEF_ENTER_SHIFT,
  parameter int EXIT_SHIFT   = DEF_EXIT_SHIFT,
  parameter int OFF_SAMPLES  = DEF_OFF_SAMPLES,
  parameter bit FAST_SIM     = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ld_vld,
  input  logic [LD_W-1:0] lft_ld,
  input  logic [LD_W-1:0] rght_ld,
  output logic            en_steer,
  output logic            rider_off,
  output logic            ld_fault
);

  localparam int unsigned TMR_TICKS = tmr_ticks(FAST_SIM);
  localparam logic [LD_W:0] LO_THR = (LD_W+1)'(MIN_RIDER_WT - WT_HYST);
  localparam logic [LD_W:0] HI_THR = (LD_W+1)'(MIN_RIDER_WT + WT_HYST);
  localparam int OFF_W = $clog2(OFF_SAMPLES + 1);
  localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(OFF_SAMPLES - 1);
  localparam logic [OFF_W-1:0] OFF_MAX  = OFF_W'(OFF_SAMPLES);

  steer_state_e       state;
  steer_state_e       state_nxt;
  logic [OFF_W-1:0]   off_cnt;
  logic [LD_W:0]      sum;
  logic signed [LD_W:0] diff;
  logic signed [LD_W:0] neg_diff;
  logic [LD_W-1:0]    abs_diff;
  logic               sum_lt_min;
  logic               sum_gt_min;
  logic               enter_lean;
  logic               exit_lean;
  logic               saturated;
  logic               low_wt;
  logic               lean_clr;
  logic               tmr_full;

  // One extra bit on sum and diff keeps every input pair overflow-free.
  assign sum      = {1'b0, lft_ld} + {1'b0, rght_ld};
  assign diff     = $signed({1'b0, lft_ld}) - $signed({1'b0, rght_ld});
  assign neg_diff = -diff;
  assign abs_diff = diff[LD_W] ? neg_diff[LD_W-1:0] : diff[LD_W-1:0];

  assign sum_lt_min = (sum < LO_THR);
  assign sum_gt_min = (sum > HI_THR);
  assign enter_lean = ({1'b0, abs_diff} > (sum >> ENTER_SHIFT));
  assign exit_lean  = ({1'b0, abs_diff} > (sum - (sum >> EXIT_SHIFT)));
  assign saturated  = (lft_ld == '1) || (rght_ld == '1);

  // Rider is off once this sample completes the run of consecutive light samples.
  assign low_wt = ld_vld && sum_lt_min && (off_cnt >= OFF_LAST);

  // Next-state decode; every transition is sample driven, saturation overrides all.
  always_comb begin
    state_nxt = state;
    lean_clr  = 1'b0;
    if (ld_vld) begin
      if (saturated) begin
        state_nxt = ST_FAULT;
      end else begin
        case (state)
          ST_IDLE: begin
            if (sum_gt_min) state_nxt = ST_WAIT;
          end
          ST_WAIT: begin
            if (low_wt)          state_nxt = ST_IDLE;
            else if (enter_lean) lean_clr  = 1'b1;
            else if (tmr_full)   state_nxt = ST_STEER;
          end
          ST_STEER: begin
            if (low_wt)         state_nxt = ST_IDLE;
            else if (exit_lean) state_nxt = ST_WAIT;
          end
          default: ;
        endcase
      end
    end
  end

  // Timer only runs across consecutive WAIT cycles, so entry and exit both leave it at zero.
  steer_tmr #(
    .TMR_TICKS (TMR_TICKS)
  ) u_tmr (
    .clk   (clk),
    .rst_n (rst_n),
    .run   ((state == ST_WAIT) && (state_nxt == ST_WAIT)),
    .clr   (lean_clr),
    .full  (tmr_full)
  );

  // State, off-debounce counter and output decodes of the current state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      off_cnt   <= '0;
      en_steer  <= 1'b0;
      rider_off <= 1'b1;
      ld_fault  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        off_cnt <= '0;
      end else if (ld_vld) begin
        if (!sum_lt_min)            off_cnt <= '0;
        else if (off_cnt != OFF_MAX) off_cnt <= off_cnt + 1'b1;
      end
      en_steer  <= (state == ST_STEER);
      rider_off <= (state == ST_IDLE) || (state == ST_FAULT);
      ld_fault  <= (state == ST_FAULT);
    end
  end

endmodule

// File: tb/tb_steer_en_ctrl.sv
// tb/tb_steer_en_ctrl.sv - randomized and directed bench against a behavioural model
module tb_steer_en_ctrl;

  localparam int TICKS = 16384;
  localparam int M_IDLE = 0, M_WAIT = 1, M_STEER = 2, M_FAULT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_vld = 1'b0;
  logic [11:0] lft_ld = '0;
  logic [11:0] rght_ld = '0;
  logic        en_steer;
  logic        rider_off;
  logic        ld_fault;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  int   m_st = M_IDLE;
  int   m_low = 0;
  int   m_entry = 0;
  logic e_en = 1'b0;
  logic e_off = 1'b1;
  logic e_flt = 1'b0;

  always #5 clk = ~clk;

  steer_en_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ld_vld    (ld_vld),
    .lft_ld    (lft_ld),
    .rght_ld   (rght_ld),
    .en_steer  (en_steer),
    .rider_off (rider_off),
    .ld_fault  (ld_fault)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Rules applied per clock edge: elapsed time since WAIT entry and a run length of light samples.
  task automatic model_step(input logic v, input int l, input int r);
    int sum, ad, nst;
    bit light, heavy, gone;
    if (!rst_n) begin
      m_st = M_IDLE; m_low = 0;
      e_en = 1'b0; e_off = 1'b1; e_flt = 1'b0;
      return;
    end
    e_en  = (m_st == M_STEER);
    e_off = (m_st == M_IDLE) || (m_st == M_FAULT);
    e_flt = (m_st == M_FAULT);
    nst = m_st;
    if (v) begin
      sum = l + r;
      ad  = (l > r) ? l - r : r - l;
      light = sum < 'h1C0;
      heavy = sum > 'h240;
      m_low = light ? m_low + 1 : 0;
      gone  = m_low >= 4;
      if (l == 4095 || r == 4095) nst = M_FAULT;
      else if (m_st == M_IDLE) begin
        if (heavy) nst = M_WAIT;
      end else if (m_st == M_WAIT) begin
        if (gone) nst = M_IDLE;
        else if (ad > sum / 4) m_entry = cyc;
        else if (cyc - m_entry >= TICKS) nst = M_STEER;
      end else if (m_st == M_STEER) begin
        if (gone) nst = M_IDLE;
        else if (ad > sum - sum / 16) nst = M_WAIT;
      end
    end
    if (nst != m_st) begin
      m_low = 0;
      if (nst == M_WAIT) m_entry = cyc;
    end
    m_st = nst;
  endtask

  task automatic cycle(input logic v, input logic [11:0] l, input logic [11:0] r);
    ld_vld = v; lft_ld = l; rght_ld = r;
    @(posedge clk);
    cyc++;
    model_step(v, int'(l), int'(r));
    #1;
    chk("outs", {29'd0, en_steer, rider_off, ld_fault}, {29'd0, e_en, e_off, e_flt});
  endtask

  initial begin
    int s, fall, rise, t0, pat, len, base, tgt;
    logic v;
    logic [11:0] l, r;

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) cycle(1'($urandom_range(0, 1)), 12'($urandom_range(0, 'hFFE)), 12'($urandom_range(0, 'hFFE)));
    chk("reset_outs", {29'd0, en_steer, rider_off, ld_fault}, 32'h2);
    rst_n = 1'b1;

    for (int i = 0; i < 50; i++) cycle(1'b1, 12'h120, 12'h120);
    chk("boundary_idle", {31'd0, rider_off}, 32'd1);

    s = cyc; fall = -1; rise = -1;
    for (int i = 0; i < 17000 && rise < 0; i++) begin
      cycle(1'b1, 12'h150, 12'h150);
      if (fall < 0 && rider_off === 1'b0) fall = cyc - s;
      if (en_steer === 1'b1) rise = cyc - s;
    end
    chk("off_fall_lat", fall, 2);
    chk("steer_lat", rise, 16386);

    cycle(1'b1, 12'h2A0, 12'h000);
    cycle(1'b1, 12'h150, 12'h150);
    chk("exit_lean_en", {31'd0, en_steer}, 32'd0);
    for (int i = 0; i < 15999; i++) cycle(1'b1, 12'h150, 12'h150);
    s = cyc; rise = -1;
    cycle(1'b1, 12'h1F0, 12'h0B0);
    for (int i = 0; i < 17000 && rise < 0; i++) begin
      cycle(1'b1, 12'h150, 12'h150);
      if (en_steer === 1'b1) rise = cyc - s;
    end
    chk("lean_restart_lat", rise, 16386);

    for (int i = 0; i < 3; i++) cycle(1'b1, 12'h080, 12'h080);
    chk("off3_en", {31'd0, en_steer}, 32'd1);
    cycle(1'b1, 12'h080, 12'h080);
    cycle(1'b1, 12'h080, 12'h080);
    chk("off4_en", {31'd0, en_steer}, 32'd0);
    chk("off4_rider", {31'd0, rider_off}, 32'd1);

    t0 = cyc;
    while (cyc - t0 < 20000) begin
      pat = $urandom_range(0, 4);
      len = (pat == 2 && $urandom_range(0, 2) == 0) ? 16500 : $urandom_range(1, 400);
      if ($urandom_range(0, 19) == 0) begin
        rst_n = 1'b0;
        cycle(1'b1, 12'h150, 12'h150);
        rst_n = 1'b1;
      end
      base = $urandom_range('h140, 'h300);
      tgt  = ($urandom_range(0, 1) == 1) ? 'h1C0 : 'h240;
      for (int i = 0; i < len; i++) begin
        v = ($urandom_range(0, 7) != 0);
        case (pat)
          0: begin l = 12'($urandom_range(0, 'hDF)); r = 12'($urandom_range(0, 'hDF)); end
          1: begin l = 12'($urandom_range(0, tgt)); r = 12'(tgt) - l; end
          2: begin l = 12'(base); r = 12'(base + $urandom_range(0, 'h20)); end
          3: begin l = 12'($urandom_range('h200, 'h7FF)); r = 12'($urandom_range(0, 'h40)); end
          default: begin l = 12'($urandom_range(0, 'hFFE)); r = 12'($urandom_range(0, 'hFFE)); end
        endcase
        cycle(v, l, r);
      end
    end

    for (int i = 0; i < 5; i++) cycle(1'b1, 12'h150, 12'h150);
    cycle(1'b1, 12'hFFF, 12'h010);
    for (int i = 0; i < 20; i++) cycle(1'b1, 12'h150, 12'h150);
    chk("fault_flag", {31'd0, ld_fault}, 32'd1);
    chk("fault_en", {31'd0, en_steer}, 32'd0);
    chk("fault_rider", {31'd0, rider_off}, 32'd1);
    rst_n = 1'b0;
    cycle(1'b1, 12'h150, 12'h150);
    cycle(1'b1, 12'h150, 12'h150);
    rst_n = 1'b1;
    chk("fault_cleared", {31'd0, ld_fault}, 32'd0);
    cycle(1'b1, 12'h100, 12'hFFF);
    cycle(1'b1, 12'h100, 12'h100);
    chk("fault_right", {31'd0, ld_fault}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/steer_en_ctrl.md
STEER_EN_CTRL -- requirements
Module: steer_en_ctrl

Interface
REQ-001 Parameter LD_W, default 12: width of each load-cell input.
REQ-002 Parameter MIN_RIDER_WT, default 'h200: nominal rider-present weight threshold on the load sum.
REQ-003 Parameter WT_HYST, default 'h40: hysteresis applied each side of MIN_RIDER_WT.
REQ-004 Parameter ENTER_SHIFT, default 2: lean threshold for arming, |diff| > sum>>ENTER_SHIFT (1/4).
REQ-005 Parameter EXIT_SHIFT, default 4: lean threshold for disarming, |diff| > sum - (sum>>EXIT_SHIFT) (15/16).
REQ-006 Parameter OFF_SAMPLES, default 4: consecutive valid low-weight samples required before declaring rider off.
REQ-007 Parameter FAST_SIM, default 1: selects TMR_TICKS = 2**14 when 1, 67,000,000 when 0.
REQ-008 clk  input  1  system clock; all state changes on rising edge.
REQ-009 rst_n  input  1  synchronous, active-low reset.
REQ-010 ld_vld  input  1  strobe, high for one cycle when lft_ld/rght_ld carry a new sample.
REQ-011 lft_ld  input  LD_W  left load-cell reading, unsigned.
REQ-012 rght_ld  input  LD_W  right load-cell reading, unsigned.
REQ-013 en_steer  output  1  registered; high only while the controller is in STEER.
REQ-014 rider_off  output  1  registered; high while the controller is in IDLE.
REQ-015 ld_fault  output  1  registered; sticky sensor-saturation flag.

Function
REQ-016 sum SHALL be LD_W+1 bits unsigned; diff SHALL be computed LD_W+1 bits signed; abs_diff SHALL be LD_W bits with no overflow for any input pair.
REQ-017 sum_lt_min = sum < MIN_RIDER_WT-WT_HYST; sum_gt_min = sum > MIN_RIDER_WT+WT_HYST; both strict compares, evaluated only on ld_vld cycles.
REQ-018 States: IDLE, WAIT, STEER, FAULT; reset state IDLE.
REQ-019 IDLE: on ld_vld with sum_gt_min -> WAIT with timer cleared; otherwise stay.
REQ-020 WAIT: on ld_vld, low-weight condition met (REQ-023) -> IDLE; else enter-lean true -> stay, timer cleared; else timer full -> STEER.
REQ-021 STEER: on ld_vld, low-weight condition met -> IDLE; else exit-lean true -> WAIT with timer cleared.
REQ-022 Timer SHALL count every clk in WAIT regardless of ld_vld, be full when count == TMR_TICKS-1, and hold cleared in all other states.
REQ-023 Off-debounce counter SHALL increment on each ld_vld with sum_lt_min, clear on ld_vld without it; low-weight condition = counter reaches OFF_SAMPLES; counter clears on every state change.
REQ-024 Any ld_vld sample with lft_ld or rght_ld all-ones SHALL move the controller to FAULT from any state, taking priority over all other transitions.
REQ-025 FAULT is exited only by reset; en_steer=0, rider_off=1, ld_fault=1 in FAULT.
REQ-026 Outputs SHALL be registered decodes of the state register, valid one clk after the state register updates.
REQ-027 Simultaneous timer full and enter-lean in WAIT: lean wins, timer clears, no STEER entry.
REQ-028 Sum exactly at MIN_RIDER_WT±WT_HYST SHALL trigger neither compare.

Reset
REQ-029 While rst_n is low at a clk edge: state IDLE, timer 0, off-debounce counter 0, en_steer=0, rider_off=1, ld_fault=0.
REQ-030 Reset asserted mid-WAIT or mid-STEER SHALL take effect at the next edge with no partial state retained.

Structure
REQ-031 Package steer_en_pkg SHALL hold the state enum and default threshold/timer constants.
REQ-032 Timer and its full compare SHALL be sub-module steer_tmr, parameterised by TMR_TICKS.

Verification (LD_W=12, FAST_SIM=1, defaults, ld_vld every cycle)
REQ-033 Reset held 3 cycles -> en_steer=0, rider_off=1, ld_fault=0.
REQ-034 lft=rght='h150 (sum 'h2A0) -> rider_off falls 2 clks later; en_steer rises 16384+2 clks after WAIT entry.
REQ-035 lft=rght='h120 (sum 'h240, boundary) -> remains IDLE, rider_off=1 indefinitely.
REQ-036 In WAIT lft='h1F0, rght='hB0 (|diff| 'h140 > 'hA8) at count 16000 -> timer restarts, en_steer stays 0.
REQ-037 In STEER lft='h2A0, rght=0 (|diff| 'h2A0 > 'h276) -> WAIT, en_steer=0 next clk; sum 'h100 for 3 samples -> still STEER, 4th -> IDLE, rider_off=1.
REQ-038 lft='hFFF in any state -> ld_fault=1, en_steer=0 until reset.
